// File: rtl/speed_uart_tx_if.sv
// Result bus from the speed-measurement datapath: one speed value qualified
// by a single-cycle done strobe.
interface speed_uart_tx_if #(
  parameter int WIDTH_SPEED = 14
);
  logic [WIDTH_SPEED-1:0] speed;
  logic                   done;

  modport master (output speed, output done);
  modport slave  (input  speed, input  done);
endinterface

// File: rtl/speed_uart_tx.sv
// Converts each accepted speed result to five ASCII decimal digits plus CR LF
// and shifts the 7-byte record out on an 8N1 UART line.
module speed_uart_tx #(
  parameter int WIDTH_SPEED = 14,
  parameter int SYS_FREQ    = 50000000,
  parameter int BAUD        = 115200
) (
  input  logic                   clk,
  input  logic                   reset_n,
  speed_uart_tx_if.slave         res_if,
  output logic                   tx_o,
  output logic                   busy_o,
  output logic                   overrun_o
);

  localparam int CLKS_PER_BIT = SYS_FREQ / BAUD;
  localparam int BAUD_W       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [4:0]        CNT_INIT  = 5'(WIDTH_SPEED);

  typedef enum logic [1:0] {IDLE, CONV, SEND} state_e;

  state_e                 state_q, state_d;
  logic [WIDTH_SPEED-1:0] shift_q, shift_d;
  logic [19:0]            bcd_q, bcd_d;
  logic [4:0]             cnt_q, cnt_d;
  logic [2:0]             byte_q, byte_d;
  logic [3:0]             bit_q, bit_d;
  logic [BAUD_W-1:0]      baud_q, baud_d;
  logic                   tx_q, tx_d;
  logic                   busy_q, busy_d;
  logic                   overrun_q, overrun_d;

  logic [19+WIDTH_SPEED:0] dabble;
  logic [7:0]              curByte;
  logic [15:0]             frame;

  // One double-dabble step: add 3 to every BCD nibble >= 5, then shift left.
  always_comb begin
    dabble = {bcd_q, shift_q};
    for (int i = 0; i < 5; i++) begin
      if (dabble[WIDTH_SPEED+4*i +: 4] >= 4'd5) begin
        dabble[WIDTH_SPEED+4*i +: 4] = dabble[WIDTH_SPEED+4*i +: 4] + 4'd3;
      end
    end
    dabble = dabble << 1;
  end

  always_comb begin
    case (byte_q)
      3'd0:    curByte = 8'h30 + {4'h0, bcd_q[19:16]};
      3'd1:    curByte = 8'h30 + {4'h0, bcd_q[15:12]};
      3'd2:    curByte = 8'h30 + {4'h0, bcd_q[11:8]};
      3'd3:    curByte = 8'h30 + {4'h0, bcd_q[7:4]};
      3'd4:    curByte = 8'h30 + {4'h0, bcd_q[3:0]};
      3'd5:    curByte = 8'h0D;
      default: curByte = 8'h0A;
    endcase
  end

  // Bit index 0 is the start bit, 1..8 data LSB first, 9 stop; index 10 is a
  // one-cycle tail so the registered stop bit is held for its full period.
  assign frame = {7'h7F, curByte, 1'b0};

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bcd_d     = bcd_q;
    cnt_d     = cnt_q;
    byte_d    = byte_q;
    bit_d     = bit_q;
    baud_d    = baud_q;
    tx_d      = 1'b1;
    overrun_d = res_if.done && (state_q != IDLE);

    case (state_q)
      IDLE: begin
        if (res_if.done) begin
          state_d = CONV;
          shift_d = res_if.speed;
          bcd_d   = '0;
          cnt_d   = CNT_INIT;
        end
      end
      CONV: begin
        {bcd_d, shift_d} = dabble;
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == 5'd1) begin
          state_d = SEND;
          byte_d  = '0;
          bit_d   = '0;
          baud_d  = '0;
        end
      end
      SEND: begin
        tx_d = frame[bit_q];
        if (bit_q == 4'd10) begin
          state_d = IDLE;
        end else if (baud_q == BAUD_LAST) begin
          baud_d = '0;
          if (bit_q == 4'd9 && byte_q != 3'd6) begin
            bit_d  = '0;
            byte_d = byte_q + 3'd1;
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bcd_q     <= '0;
      cnt_q     <= '0;
      byte_q    <= '0;
      bit_q     <= '0;
      baud_q    <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bcd_q     <= bcd_d;
      cnt_q     <= cnt_d;
      byte_q    <= byte_d;
      bit_q     <= bit_d;
      baud_q    <= baud_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      overrun_q <= overrun_d;
    end
  end

  assign tx_o      = tx_q;
  assign busy_o    = busy_q;
  assign overrun_o = overrun_q;

endmodule

// File: doc/speed_uart_tx.md
# speed_uart_tx

Serialises each speed result into a fixed ASCII record and transmits it on a UART line (8N1) to the roadside display/host. Sits downstream of the speed-measurement datapath: it consumes the `speed` value and its single-cycle `done` strobe, converts the binary value to five decimal digits by double-dabble, and sends `DDDDD\r\n`. Results arriving while a record is in flight are dropped and flagged.

## Interface
- `WIDTH_SPEED`, 14: width of `speed`; legal range 1..16, so the value always fits in five decimal digits.
- `SYS_FREQ`, 50000000: clock frequency in Hz.
- `BAUD`, 115200: line rate; `CLKS_PER_BIT = SYS_FREQ/BAUD` with integer truncation, giving 434 at the defaults.

- `clk`  in  1  system clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `speed`  in  WIDTH_SPEED  unsigned speed value; sampled only in the cycle `done` is high.
- `done`  in  1  single-cycle strobe marking `speed` valid.
- `tx`  out  1  UART line; idles high.
- `busy`  out  1  high while a record is being converted or sent.
- `overrun`  out  1  one-cycle pulse when a `done` is dropped.

## Operation
- **Reset values:** `tx` = 1, `busy` = 0, `overrun` = 0, state = IDLE. All internal registers are cleared.
- **States:** IDLE -> CONV -> SEND -> IDLE.
- **IDLE**
  - `busy` = 0 and `tx` = 1.
  - On a clock edge with `done` = 1: latch `speed`, clear the 20-bit BCD register, load the bit counter with WIDTH_SPEED, and go to CONV.
- **CONV (double-dabble), one iteration per cycle:**
  - Each of the five BCD nibbles that is ≥5 gets +3.
  - Then {BCD, shift} is shifted left by 1.
  - After exactly WIDTH_SPEED iterations, go to SEND with byte index 0.
- **SEND**
  - Transmits 7 bytes in order:
    - digits 10^4, 10^3, 10^2, 10^1, 10^0 as `0x30 + nibble`;
    - then `0x0D`;
    - then `0x0A`.
  - Leading zeros are sent; the record is always 7 bytes.
- **Byte framing:**
  - Start bit 0, then 8 data bits LSB first, then stop bit 1.
  - Each bit is held for exactly CLKS_PER_BIT cycles.
  - The next byte's start bit directly follows the previous stop bit, with no idle gap.
  - After the last stop bit has been held for its full CLKS_PER_BIT cycles, go to IDLE.
- **`done` while busy (CONV or SEND):**
  - The value is ignored.
  - `overrun` = 1 for the following cycle.
  - The in-flight record is unaffected.
- **`done` in the same cycle the FSM returns to IDLE:** treated as busy, i.e. dropped with `overrun`. Acceptance requires state = IDLE at the sampling edge.
- **Reset asserted mid-record:**
  - `tx` goes to 1 immediately (asynchronously).
  - The record is abandoned; no partial byte resumes after reset.
- `speed` is treated as unsigned; no saturation is needed because WIDTH_SPEED ≤ 16 implies a value ≤ 65535.

## Timing
- **Clock edges:** E0 is the edge that samples `done` = 1 in IDLE.
- **`busy`:** registered; goes 1 after E0.
- **CONV:** occupies the WIDTH_SPEED cycles following E0.
- **First start bit:** `tx` falls to 0 after edge E0 + WIDTH_SPEED + 1. That is E0 + 15 at defaults.
- **Bit boundaries:** each bit boundary is exactly CLKS_PER_BIT edges after the previous one.
- **Record length:** 70 bit periods, i.e. 70 × 434 = 30380 cycles at defaults.
- **Return to idle:** `busy` falls after edge E0 + WIDTH_SPEED + 1 + 70·CLKS_PER_BIT. `tx` is 1 from the last stop bit onward.
- **`overrun`:** asserted after the edge that sampled the rejected `done`; deasserted after the next edge.
- **Latency from `done` to the first data bit** = WIDTH_SPEED + 1 + CLKS_PER_BIT cycles.
- **Throughput:** at most one record per (WIDTH_SPEED + 1 + 70·CLKS_PER_BIT + 1) cycles.

## Test plan
- **Nominal value:** `speed` = 1234 with a `done` pulse.
  - Decoded bytes are 0x30, 0x31, 0x32, 0x33, 0x34, 0x0D, 0x0A.
  - `busy` is high for 15 + 30380 cycles and `overrun` stays 0.
- **Zero and maximum:**
  - `speed` = 0 gives "00000\r\n".
  - `speed` = 16383 gives 0x31, 0x36, 0x33, 0x38, 0x33, 0x0D, 0x0A.
  - `speed` = 14400 gives "14400\r\n".
- **Bit timing:** measure every `tx` edge for `speed` = 85 (0x38, 0x35).
  - Start bit falls at E0 + 15.
  - Every bit period is 434 cycles.
  - There is no gap between the stop and start bits of adjacent bytes.
- **Overrun:**
  - Send `done` with 500, then `done` with 999 at E0 + 1000.
  - Expect a one-cycle `overrun` pulse and the record "00500\r\n" only.
  - A subsequent `done` after `busy` falls transmits normally.
- **Reset mid-record:**
  - Assert `reset_n` = 0 during the third data bit of byte 2.
  - `tx` = 1 and `busy` = 0 immediately.
  - After release, `done` with 42 gives a clean "00042\r\n".
- **Back-to-back:** assert `done` on the first cycle `busy` = 0 after a record. It is accepted with no `overrun`, and the start bit comes 15 cycles later.
